// File: rtl/shift_seq_ctrl.sv
// Serial shift-register sequencer: loads a parallel word, shifts it out MSB-first
// on sd_out while capturing sd_in, and reports the received word at frame end.
module shift_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             sd_in,
  output logic             sd_out,
  output logic             shift_en,
  output logic             frame
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [WIDTH-1:0] rx_data_q;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             div_term;
  logic             last_bit;

  assign div_term      = (div_cnt == DIV_LAST);
  assign last_bit      = (bit_cnt == BIT_LAST);
  assign shreg_shifted = {shreg[WIDTH-2:0], sd_in};

  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    frame     = 1'b0;
    sd_out    = 1'b0;
    shift_en  = 1'b0;
    rx_valid  = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = ~rst;
        if (tx_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        frame    = 1'b1;
        sd_out   = shreg[WIDTH-1];
        shift_en = div_term;
        if (div_term && last_bit) state_nxt = DONE;
      end
      DONE: begin
        rx_valid  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_data = rx_data_q;

  // Reset clears the datapath too, so an aborted frame leaves no stale word behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      rx_data_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg   <= tx_data;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (div_term) begin
            shreg   <= shreg_shifted;
            div_cnt <= '0;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) rx_data_q <= shreg_shifted;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_shift_seq_ctrl;

  localparam int MW = 8;
  localparam int MD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [MW-1:0] rx_data;
  logic          rx_valid;
  logic          sd_in;
  logic          sd_out;
  logic          shift_en;
  logic          frame;
  logic          lb = 1'b1;
  logic          sd_fix = 1'b0;

  logic [3:0]    tx_data_b = '0;
  logic          tx_valid_b = 1'b0;
  logic          tx_ready_b;
  logic [3:0]    rx_data_b;
  logic          rx_valid_b;
  logic          sd_in_b;
  logic          sd_out_b;
  logic          shift_en_b;
  logic          frame_b;

  int tests = 0;
  int fails = 0;

  assign sd_in   = lb ? sd_out : sd_fix;
  assign sd_in_b = sd_out_b;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(MW), .CLK_DIV(MD)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .sd_in(sd_in), .sd_out(sd_out),
    .shift_en(shift_en), .frame(frame)
  );

  shift_seq_ctrl #(.WIDTH(4), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .sd_in(sd_in_b), .sd_out(sd_out_b),
    .shift_en(shift_en_b), .frame(frame_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: position in the frame is counted in cycles since accept.
  logic          m_ok = 1'b0;
  logic          m_active = 1'b0;
  int            m_t = 0;
  logic [MW-1:0] m_tx = '0;
  logic [MW-1:0] m_acc = '0;
  logic [MW-1:0] m_rx_data = '0;

  always begin
    logic s_rst, s_valid, s_sdin;
    logic [MW-1:0] s_data;
    logic in_shift;
    int k;
    @(posedge clk);
    s_rst = rst; s_valid = tx_valid; s_data = tx_data; s_sdin = sd_in;
    if (s_rst) begin
      m_ok = 1'b1; m_active = 1'b0; m_t = 0; m_rx_data = '0;
    end else if (m_active) begin
      if (m_t <= MW*MD && (m_t % MD) == 0) m_acc = {m_acc[MW-2:0], s_sdin};
      if (m_t == MW*MD) m_rx_data = m_acc;
      if (m_t == MW*MD + 1) m_active = 1'b0;
      else m_t++;
    end else if (s_valid) begin
      m_active = 1'b1; m_t = 1; m_tx = s_data; m_acc = '0;
    end
    @(negedge clk);
    if (m_ok) begin
      in_shift = m_active && m_t >= 1 && m_t <= MW*MD;
      k = in_shift ? (m_t - 1) / MD : 0;
      chk("frame", frame, in_shift);
      chk("sd_out", sd_out, in_shift ? m_tx[MW-1-k] : 1'b0);
      chk("shift_en", shift_en, in_shift && (m_t % MD) == 0);
      chk("rx_valid", rx_valid, m_active && m_t == MW*MD + 1);
      chk("tx_ready", tx_ready, !m_active && !rst);
      chk("rx_data", rx_data, m_rx_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_frame(input logic [MW-1:0] d, output logic [15:0] seq, output int se,
                           output int rxv_at, output logic [MW-1:0] rxd);
    tx_data = d; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    seq = '0; se = 0; rxv_at = -1; rxd = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 16) seq[16-c] = sd_out;
      se += int'(shift_en);
      if (rx_valid && rxv_at < 0) begin rxv_at = c; rxd = rx_data; end
      step();
    end
  endtask

  initial begin
    logic [15:0] seq;
    int se, rxv_at, na, nr, nse;
    logic [MW-1:0] rxd;
    int acc_at[2];
    logic [MW-1:0] rxv[2];
    logic [7:0] se_b;

    // Power-up: three reset edges.
    step();
    chk("rst_tx_ready", tx_ready, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("pu_rx_valid", rx_valid, 1'b0);
    chk("pu_frame", frame, 1'b0);
    chk("pu_sd_out", sd_out, 1'b0);
    chk("pu_rx_data", rx_data, 8'h00);
    chk("pu_tx_ready", tx_ready, 1'b1);

    // Loopback 0xA5.
    lb = 1'b1;
    run_frame(8'hA5, seq, se, rxv_at, rxd);
    chk("a5_seq", seq, 16'hCC33);
    chk("a5_shift_cnt", se, 8);
    chk("a5_rxv_at", rxv_at, 17);
    chk("a5_rx_data", rxd, 8'hA5);

    // sd_in held high, send 0x00.
    lb = 1'b0; sd_fix = 1'b1;
    run_frame(8'h00, seq, se, rxv_at, rxd);
    chk("ones_seq", seq, 16'h0000);
    chk("ones_rx_data", rxd, 8'hFF);
    lb = 1'b1; sd_fix = 1'b0;

    // Back-to-back with tx_valid held high.
    tx_data = 8'h3C; tx_valid = 1'b1;
    na = 0; nr = 0;
    for (int c = 0; c < 46; c++) begin
      if (tx_ready && tx_valid && na < 2) begin acc_at[na] = c; na++; end
      step();
      if (na == 1) tx_data = 8'hC3;
      if (na == 2) tx_valid = 1'b0;
      if (rx_valid && nr < 2) begin rxv[nr] = rx_data; nr++; end
    end
    chk("b2b_accepts", na, 2);
    chk("b2b_rx_count", nr, 2);
    if (na == 2) chk("b2b_interval", acc_at[1] - acc_at[0], 18);
    if (nr == 2) begin
      chk("b2b_rx0", rxv[0], 8'h3C);
      chk("b2b_rx1", rxv[1], 8'hC3);
    end

    // Reset after the third shift_en of a frame.
    tx_data = 8'h5A; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    nse = 0;
    for (int c = 0; c < 20 && nse < 3; c++) begin
      nse += int'(shift_en);
      if (nse < 3) step();
    end
    chk("mid_shift_seen", nse, 3);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_ready", tx_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_frame", frame, 1'b0);
    chk("mid_sd_out", sd_out, 1'b0);
    chk("mid_rx_data", rx_data, 8'h00);
    chk("mid_tx_ready", tx_ready, 1'b1);
    nr = 0;
    for (int c = 0; c < 20; c++) begin
      nr += int'(rx_valid);
      step();
    end
    chk("mid_no_rx_valid", nr, 0);

    // WIDTH=4, CLK_DIV=1 loopback of 0x9.
    tx_data_b = 4'h9; tx_valid_b = 1'b1;
    step();
    tx_valid_b = 1'b0;
    se_b = '0; rxv_at = -1; rxd = '0;
    for (int c = 1; c <= 8; c++) begin
      se_b[8-c] = shift_en_b;
      if (rx_valid_b && rxv_at < 0) begin rxv_at = c; rxd = {4'h0, rx_data_b}; end
      step();
    end
    chk("b_shift_en", se_b, 8'hF0);
    chk("b_rxv_at", rxv_at, 5);
    chk("b_rx_data", rxd, 8'h09);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the team's serial shift-register datapath. Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on `sd_out`. Simultaneously samples `sd_in` into the same register, so one frame returns a received parallel word. The block generates the per-bit `shift_en` strobe, the frame envelope and the completion pulse. It sits between a parallel producer/consumer and a serial link or a chain of shift-register stages.

## Interface
Parameters:
- `WIDTH`, 8: bits per frame; ≥2.
- `CLK_DIV`, 2: clock cycles per bit period; ≥1.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `tx_data`  in  WIDTH  parallel word to send.
- `tx_valid`  in  1  producer has a word.
- `tx_ready`  out  1  controller can accept a word.
- `rx_data`  out  WIDTH  word captured from `sd_in`, held until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated.
- `sd_in`  in  1  serial input.
- `sd_out`  out  1  serial output; equals the shift register MSB.
- `shift_en`  out  1  one-cycle strobe on each bit shift.
- `frame`  out  1  high while a frame is in progress.

## Operation
- States:
  - IDLE: `tx_ready`=1, `sd_out`=0, `frame`=0.
  - SHIFT: `frame`=1, `sd_out`=shreg[WIDTH-1].
  - DONE: `rx_valid`=1, lasts exactly one cycle, then returns to IDLE.
- IDLE→SHIFT on `tx_valid && tx_ready`:
  - shreg ← `tx_data`
  - divider ← 0
  - bit counter ← 0
- SHIFT divider:
  - Counts 0..CLK_DIV-1.
  - On the terminal count: `shift_en`=1 and shreg ← {shreg[WIDTH-2:0], sd_in}. `sd_in` is sampled on that same edge.
  - On the same terminal count: bit counter increments and divider returns to 0.
- SHIFT→DONE when the WIDTH-th shift occurs. On that edge, `rx_data` ← the post-shift shreg value.
- Loopback (`sd_out` tied to `sd_in`) rotates the word a full turn, so `rx_data` = `tx_data`.
- `tx_valid` is ignored outside IDLE. `tx_data` is sampled only on the handshake edge and may change afterwards.
- CLK_DIV=1: `shift_en` is high on every SHIFT cycle.
- Divider width: clog2(CLK_DIV), minimum 1 bit. Bit counter width: clog2(WIDTH+1).
- Reset:
  - While `rst` is high on an edge: state←IDLE, shreg←0, divider←0, bit counter←0, `rx_data`←0.
  - `tx_ready` is forced to 0 during any cycle in which `rst`=1.
  - All other outputs read 0 after the reset edge.
- Reset mid-frame: the frame is aborted with no `rx_valid` pulse. `sd_out`/`frame` are 0 from the next cycle, and `rx_data` is cleared to 0.

## Timing
- Handshake accepted on edge T. Cycle after T: `frame`=1 and `sd_out`=tx_data[WIDTH-1].
- Bit k (k=1..WIDTH) shifts on edge T + k·CLK_DIV. `sd_out` then presents original bit WIDTH-1-k.
- The `shift_en` cycle is the last cycle the current `sd_out` bit is valid.
- DONE occupies the cycle after edge T + WIDTH·CLK_DIV:
  - `rx_valid`=1 and `rx_data` valid in that cycle.
  - `frame`=0 in that cycle.
- `tx_ready`=1 in the following cycle. The minimum accept-to-accept interval is WIDTH·CLK_DIV + 2 cycles.
- Outputs are registered or decoded from state only, with no combinational path from inputs. Exception: `tx_ready` is gated by `rst`.

## Test plan
- Loopback, WIDTH=8, CLK_DIV=2, send 0xA5:
  - `sd_out` sequence 1,0,1,0,0,1,0,1, each bit held 2 cycles.
  - Exactly 8 `shift_en` pulses.
  - `rx_valid` one cycle, 17 cycles after accept, with `rx_data`=0xA5.
- `sd_in` held 1, send 0x00: `sd_out` is 0 for the whole frame; `rx_data`=0xFF.
- `tx_valid` held high, words 0x3C then 0xC3:
  - Second accept occurs exactly 18 cycles after the first.
  - `tx_valid` is ignored while `frame`=1.
  - Loopback `rx_data` values are 0x3C then 0xC3.
- Assert `rst` for 1 cycle after the 3rd `shift_en` of a frame:
  - No `rx_valid` pulse.
  - `frame`=0 and `sd_out`=0 the next cycle; `rx_data`=0.
  - `tx_ready`=1 the cycle after `rst` falls.
- CLK_DIV=1, WIDTH=4, send 0x9: `shift_en` high 4 consecutive cycles; `rx_valid` at accept+5 (loopback `rx_data`=0x9).
- Power-up: hold `rst` 3 cycles.
  - During reset: `tx_ready`=0.
  - After reset: `rx_valid`=0, `frame`=0, `sd_out`=0, `rx_data`=0.
  - `tx_ready`=1 on the first cycle after release.
